// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// default widths and the saturating wait-counter helper.
package fetch_sequencer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  // Counter stops at the limit rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    return (value >= limit) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads one word at the PC, loads it into the IR,
// pulses inc_pc, and handles flush redirects and memory timeouts.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              run,
  input  logic [DATA_W-1:0] pc_q,
  output logic              inc_pc,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              flush,
  output logic              fetch_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  fetch_state_t      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] mar_reg;
  logic [DATA_W-1:0] ir_reg;
  logic              err_reg, err_next;
  logic              load_ir;
  logic              expire;

  // True on the last permitted wait cycle: one more miss reaches TIMEOUT.
  assign expire = (cnt_reg >= TIMEOUT_LIM - 8'd1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    load_ir    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!flush && run && !err_reg) state_next = REQ;
      end
      REQ: begin
        cnt_next   = '0;
        state_next = flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          load_ir    = !flush;
          state_next = flush ? IDLE : HOLD;
        end else begin
          cnt_next = sat_inc(cnt_reg, TIMEOUT_LIM);
          if (flush) begin
            state_next = DRAIN;
          end else if (expire) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (flush)         state_next = IDLE;
        else if (ir_ready) state_next = run ? REQ : IDLE;
      end
      DRAIN: begin
        // The redirected request still owns the bus until its response lands.
        if (mem_ready) begin
          state_next = IDLE;
        end else begin
          cnt_next = sat_inc(cnt_reg, TIMEOUT_LIM);
          if (expire) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mar_reg   <= '0;
      ir_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      // MAR is captured on entry to REQ so the address is valid alongside mem_rd.
      if (state_next == REQ) mar_reg <= pc_q;
      if (load_ir)           ir_reg  <= mem_rdata;
    end
  end

  assign mem_rd    = (state_reg == REQ);
  assign ir_valid  = (state_reg == HOLD);
  assign inc_pc    = load_ir;
  assign mem_addr  = mar_reg;
  assign ir        = ir_reg;
  assign fetch_err = err_reg;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting directly downstream of the program counter register. It takes the current PC value, issues a single-word read to instruction memory over a ready/valid handshake, and captures the returned word into the instruction register (IR). It then presents the IR to decode and pulses `inc_pc` back to the PC. It also handles control-flow redirects (flush) and memory timeouts, so the PC never advances past an instruction that was not delivered.

## Interface
- `DATA_W`, 32, width of PC, memory address and instruction word.
- `TIMEOUT`, 255, maximum cycles to wait for `mem_ready` before flagging an error (1..255).

- `clock`  in  1  single system clock; all state changes on rising edge.
- `clear_n`  in  1  synchronous, active-low reset.
- `run`  in  1  level; fetching allowed while high.
- `pc_q`  in  DATA_W  current PC value.
- `inc_pc`  out  1  one-cycle pulse; PC increments by 1 (word addressing).
- `mem_addr`  out  DATA_W  memory address (MAR contents).
- `mem_rd`  out  1  read request, one cycle per fetch.
- `mem_ready`  in  1  response valid; `mem_rdata` sampled this cycle.
- `mem_rdata`  in  DATA_W  returned instruction word.
- `ir`  out  DATA_W  instruction register.
- `ir_valid`  out  1  IR holds an undelivered instruction.
- `ir_ready`  in  1  decode accepts IR when `ir_valid && ir_ready`.
- `flush`  in  1  redirect; discard current/in-flight fetch.
- `fetch_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: `run`=1 and `fetch_err`=0 -> REQ.
- REQ: MAR <= `pc_q`, `mem_rd`=1 for exactly this cycle, timeout counter <= 0 -> WAIT.
- WAIT: `mem_ready`=1 -> IR <= `mem_rdata`, `inc_pc`=1 this cycle, -> HOLD. Else counter += 1; counter reaching `TIMEOUT` -> `fetch_err` <= 1, -> IDLE, no `inc_pc`.
- HOLD: `ir_valid`=1. On accept: `run`=1 -> REQ, else IDLE. IR stable until accept.
- `flush` priority over all other transitions:
  - In WAIT without `mem_ready`: -> DRAIN.
  - In WAIT with `mem_ready`: data discarded, no `inc_pc`, -> IDLE.
  - In REQ, HOLD, IDLE: -> IDLE, `ir_valid` dropped next cycle.
- DRAIN: wait for `mem_ready`, discard data, no `inc_pc`, -> IDLE. The timeout applies here too: on expiry set `fetch_err` and go to IDLE.
- `run` deassertion never aborts a request in progress. Only flush and reset abort one.
- Timeout counter is 8 bits and never wraps. It saturates at `TIMEOUT`.

## Timing
- Reset (`clear_n`=0 at edge) -> state IDLE; `ir`=0, `mem_addr`=0, `mem_rd`=0, `inc_pc`=0, `ir_valid`=0, `fetch_err`=0. Reset mid-fetch abandons the request. The memory system is reset alongside this block.
- Minimum fetch with zero-wait memory (`mem_ready` the cycle after `mem_rd`): `run` high at edge N -> REQ at N+1, WAIT at N+2 with `ir` loaded at N+3.
- Back-to-back throughput: with `ir_ready` tied high, one instruction per 3 cycles (REQ, WAIT, HOLD).
- `inc_pc` is asserted in the same cycle the IR is loaded. PC shows the new value one cycle later, before the next REQ samples it.
- `mem_rd`, `inc_pc` and `ir_valid` are registered state decodes with no combinational path from inputs. Exception: `inc_pc` is combinational on `mem_ready` in WAIT, gated by `!flush`.

## Structure
- Shared package: state encoding constants (IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4; 3-bit), `DATA_W` default.
- Single module; no sub-module required. The timeout counter is inline.

## Test plan
- Reset then `run`=1, memory returns 0xA5A5_0001 one cycle after `mem_rd`, `ir_ready`=1 -> `mem_addr`=`pc_q`, one `inc_pc` pulse, `ir`=0xA5A5_0001, `ir_valid` for one cycle.
- Memory wait of 5 cycles, `ir_ready` held low 3 cycles in HOLD -> `ir` stable throughout, exactly one `inc_pc`, next `mem_rd` only after accept.
- `flush` in WAIT, `mem_ready` arrives 2 cycles later with 0xDEAD_BEEF -> DRAIN, no `inc_pc`, `ir` unchanged, `ir_valid`=0, back to IDLE.
- `mem_ready` never asserted, `TIMEOUT`=4 -> `fetch_err`=1 after 4 WAIT cycles, IDLE, no further `mem_rd` despite `run`=1 until reset.
- `clear_n` low during WAIT -> next cycle all outputs at reset values, then a clean fetch succeeds.
- `run`=0 during HOLD -> after accept goes to IDLE, no new `mem_rd`.
